cmp_state_tracker: RTL and testbench

- Downstream consumer of the 2-bit magnitude comparator's three result flags (a_greater_b, a_equal_b, a_lesser_b).
- Debounces the flags into a stable registered relation state, pulses on qualified state changes, and keeps saturating per-relation sample counters.
- Used wherever a noisy or toggling comparison must drive control logic: threshold alarms, crossing detection.

---
 rtl/cmp_pkg.sv | 36 +++
 rtl/sat_counter.sv | 32 +++
 rtl/cmp_state_tracker.sv | 151 +++++++++++++++
 tb/tb_cmp_state_tracker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared relation encodings and flag decode for the comparator state tracker.
// The decode reports one-hot legality separately so the CMP_ONEHOT_CHECK_EN build can drop bad samples.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'b00,
    ST_LESS    = 2'b01,
    ST_EQUAL   = 2'b10,
    ST_GREATER = 2'b11
  } rel_e;

  typedef struct packed {
    logic onehot;
    rel_e rel;
  } dec_t;

  localparam int RUN_W = 4;

  // Priority GREATER > LESS > EQUAL, so an all-zero sample reads as EQUAL.
  function automatic dec_t decode_flags(input logic gt, input logic eq, input logic lt);
    dec_t d;
    case ({gt, eq, lt})
      3'b100, 3'b010, 3'b001: d.onehot = 1'b1;
      default:                d.onehot = 1'b0;
    endcase
    if (gt) begin
      d.rel = ST_GREATER;
    end else if (lt) begin
      d.rel = ST_LESS;
    end else begin
      d.rel = ST_EQUAL;
    end
    return d;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Count register: clear, saturating increment or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/cmp_state_tracker.sv
// Debounces comparator flags into a stable relation, pulses on changes and crossings, counts samples.
// Build option CMP_ONEHOT_CHECK_EN: drop non-one-hot samples and raise a sticky err_flag.
module cmp_state_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEB_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a_greater_b,
  input  logic             a_equal_b,
  input  logic             a_lesser_b,
  input  logic             clr_cnt,
  output logic [1:0]       state,
  output logic             state_chg,
  output logic             rise_cross,
  output logic             fall_cross,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic             err_flag
);

  localparam logic [RUN_W-1:0] DEB_MAX = RUN_W'(DEB_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

  dec_t             dec_s;
  logic             accept_s;
  rel_e             state_r;
  rel_e             cand_r;
  rel_e             last_ne_r;
  rel_e             cand_nx_s;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_nx_s;
  logic             upd_s;
  logic             state_chg_r;
  logic             rise_r;
  logic             fall_r;

  assign dec_s = decode_flags(a_greater_b, a_equal_b, a_lesser_b);

`ifdef CMP_ONEHOT_CHECK_EN
  logic err_r;

  assign accept_s = in_valid & dec_s.onehot;

  // Sticky illegal-sample flag, cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (in_valid && !dec_s.onehot) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_flag = err_r;
`else
  logic dec_unused_s;

  assign accept_s     = in_valid;
  assign dec_unused_s = dec_s.onehot;
  assign err_flag     = 1'b0;
`endif

  // Next candidate/run length and whether this sample commits a new stable state.
  always_comb begin
    cand_nx_s = cand_r;
    run_nx_s  = run_r;
    upd_s     = 1'b0;
    if (accept_s) begin
      if (dec_s.rel == cand_r) begin
        if (run_r < DEB_MAX) begin
          run_nx_s = run_r + RUN_ONE;
        end else begin
          run_nx_s = DEB_MAX;
        end
      end else begin
        cand_nx_s = dec_s.rel;
        run_nx_s  = RUN_ONE;
      end
      upd_s = (run_nx_s == DEB_MAX) && (cand_nx_s != state_r);
    end else begin
      upd_s = 1'b0;
    end
  end

  // Debounce FSM with registered change and crossing pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_UNKNOWN;
      cand_r      <= ST_UNKNOWN;
      last_ne_r   <= ST_UNKNOWN;
      run_r       <= {RUN_W{1'b0}};
      state_chg_r <= 1'b0;
      rise_r      <= 1'b0;
      fall_r      <= 1'b0;
    end else begin
      state_chg_r <= 1'b0;
      rise_r      <= 1'b0;
      fall_r      <= 1'b0;
      if (accept_s) begin
        cand_r <= cand_nx_s;
        run_r  <= run_nx_s;
      end
      if (upd_s) begin
        state_r     <= cand_nx_s;
        state_chg_r <= 1'b1;
        // Crossings look past EQUAL to the last LESS/GREATER stable state.
        rise_r      <= (cand_nx_s == ST_GREATER) && (last_ne_r == ST_LESS);
        fall_r      <= (cand_nx_s == ST_LESS) && (last_ne_r == ST_GREATER);
        if (cand_nx_s != ST_EQUAL) begin
          last_ne_r <= cand_nx_s;
        end
      end
    end
  end

  assign state      = state_r;
  assign state_chg  = state_chg_r;
  assign rise_cross = rise_r;
  assign fall_cross = fall_r;

  sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_s && (dec_s.rel == ST_GREATER)),
    .clr   (clr_cnt),
    .count (gt_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_s && (dec_s.rel == ST_EQUAL)),
    .clr   (clr_cnt),
    .count (eq_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_s && (dec_s.rel == ST_LESS)),
    .clr   (clr_cnt),
    .count (lt_cnt)
  );

endmodule

// File: tb/tb_cmp_state_tracker.sv
// Bench for cmp_state_tracker: vector table, directed corner sequences and random traffic vs a history-based model.
module tb_cmp_state_tracker;
  import cmp_pkg::*;

  localparam int CNT_W   = 8;
  localparam int DEB_LEN = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             a_greater_b = 1'b0;
  logic             a_equal_b = 1'b0;
  logic             a_lesser_b = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [1:0]       state;
  logic             state_chg, rise_cross, fall_cross, err_flag;
  logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;

  always #5 clk = ~clk;

  cmp_state_tracker #(.CNT_W(CNT_W), .DEB_LEN(DEB_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a_greater_b(a_greater_b), .a_equal_b(a_equal_b), .a_lesser_b(a_lesser_b),
    .clr_cnt(clr_cnt), .state(state), .state_chg(state_chg),
    .rise_cross(rise_cross), .fall_cross(fall_cross),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err_flag(err_flag)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: stable state changes when the last DEB_LEN accepted samples agree.
  int m_state, m_lastne, m_gt, m_eq, m_lt;
  bit m_chg, m_rise, m_fall, m_err;
  int hist[$];

  task automatic model_reset();
    m_state = 0; m_lastne = 0; m_gt = 0; m_eq = 0; m_lt = 0;
    m_chg = 0; m_rise = 0; m_fall = 0; m_err = 0;
    hist.delete();
  endtask

  task automatic model_apply(input bit v, input bit g, input bit e, input bit l, input bit c);
    int rel;
    bit legal;
    bit same;
    m_chg = 0; m_rise = 0; m_fall = 0;
    legal = 1'b1;
    rel = 2;
    if (v) begin
`ifdef CMP_ONEHOT_CHECK_EN
      legal = ((int'(g) + int'(e) + int'(l)) == 1);
      if (!legal) m_err = 1'b1;
`endif
      rel = g ? 3 : (l ? 1 : 2);
    end
    if (c) begin
      m_gt = 0; m_eq = 0; m_lt = 0;
    end else if (v && legal) begin
      if (rel == 3 && m_gt < CNT_MAX) m_gt++;
      if (rel == 2 && m_eq < CNT_MAX) m_eq++;
      if (rel == 1 && m_lt < CNT_MAX) m_lt++;
    end
    if (v && legal) begin
      hist.push_back(rel);
      if (hist.size() > DEB_LEN) void'(hist.pop_front());
      same = (hist.size() == DEB_LEN);
      foreach (hist[k]) if (hist[k] != rel) same = 1'b0;
      if (same && rel != m_state) begin
        m_chg  = 1'b1;
        m_rise = (rel == 3) && (m_lastne == 1);
        m_fall = (rel == 1) && (m_lastne == 3);
        if (rel != 2) m_lastne = rel;
        m_state = rel;
      end
    end
  endtask

  task automatic check(input string name);
    logic [3*CNT_W+5:0] got, exp;
    got = {state, state_chg, rise_cross, fall_cross, err_flag, gt_cnt, eq_cnt, lt_cnt};
    exp = {2'(m_state), m_chg, m_rise, m_fall, m_err, CNT_W'(m_gt), CNT_W'(m_eq), CNT_W'(m_lt)};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got st=%0d chg=%0d r=%0d f=%0d err=%0d gt=%0d eq=%0d lt=%0d, want st=%0d chg=%0d r=%0d f=%0d err=%0d gt=%0d eq=%0d lt=%0d",
               name, state, state_chg, rise_cross, fall_cross, err_flag, gt_cnt, eq_cnt, lt_cnt,
               m_state, m_chg, m_rise, m_fall, m_err, m_gt, m_eq, m_lt);
    end
  endtask

  task automatic step(input bit v, input bit g, input bit e, input bit l, input bit c, input string name);
    in_valid = v; a_greater_b = g; a_equal_b = e; a_lesser_b = l; clr_cnt = c;
    @(posedge clk);
    model_apply(v, g, e, l, c);
    #1;
    check(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; a_greater_b = 1'b0; a_equal_b = 1'b0; a_lesser_b = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  typedef struct {
    bit v, g, e, l, c;
    int st;
    bit chg, rise, fall;
    int gtc, eqc, ltc;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(bit v, bit g, bit e, bit l, bit c, int st, bit chg, bit rise, bit fall,
                              int gtc, int eqc, int ltc);
    vec_t r;
    r.v = v; r.g = g; r.e = e; r.l = l; r.c = c;
    r.st = st; r.chg = chg; r.rise = rise; r.fall = fall;
    r.gtc = gtc; r.eqc = eqc; r.ltc = ltc;
    return r;
  endfunction

  initial begin
    int gt_before;
    int rel;
    bit g, e, l;
    logic [2:0] fl;

    //          v  g  e  l  c  st chg r  f  gt eq lt
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[2]  = mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 3);
    tbl[3]  = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3);
    tbl[4]  = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 2, 0, 3);
    tbl[5]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 2, 0, 4);
    tbl[6]  = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 3, 0, 4);
    tbl[7]  = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 4, 0, 4);
    tbl[8]  = mk(1, 1, 0, 0, 0, 3, 1, 1, 0, 5, 0, 4);
    tbl[9]  = mk(1, 0, 1, 0, 0, 3, 0, 0, 0, 5, 1, 4);
    tbl[10] = mk(1, 0, 1, 0, 0, 3, 0, 0, 0, 5, 2, 4);
    tbl[11] = mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 5, 3, 4);
    tbl[12] = mk(1, 0, 0, 1, 0, 2, 0, 0, 0, 5, 3, 5);
    tbl[13] = mk(1, 0, 0, 1, 0, 2, 0, 0, 0, 5, 3, 6);
    tbl[14] = mk(1, 0, 0, 1, 0, 1, 1, 0, 1, 5, 3, 7);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 3, 7);
    tbl[16] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

    model_reset();
    do_reset();
    expect_int("reset_state", int'(state), int'(ST_UNKNOWN));

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].g, tbl[i].e, tbl[i].l, tbl[i].c, $sformatf("tbl_model[%0d]", i));
      total++;
      if (state !== 2'(tbl[i].st) || state_chg !== tbl[i].chg || rise_cross !== tbl[i].rise ||
          fall_cross !== tbl[i].fall || gt_cnt !== CNT_W'(tbl[i].gtc) ||
          eq_cnt !== CNT_W'(tbl[i].eqc) || lt_cnt !== CNT_W'(tbl[i].ltc)) begin
        bad++;
        $display("FAIL tbl[%0d]: got st=%0d chg=%0d r=%0d f=%0d gt=%0d eq=%0d lt=%0d, want st=%0d chg=%0d r=%0d f=%0d gt=%0d eq=%0d lt=%0d",
                 i, state, state_chg, rise_cross, fall_cross, gt_cnt, eq_cnt, lt_cnt,
                 tbl[i].st, tbl[i].chg, tbl[i].rise, tbl[i].fall, tbl[i].gtc, tbl[i].eqc, tbl[i].ltc);
      end
    end

    // Saturation, then clear racing a valid sample.
    for (int i = 0; i < 260; i++) step(1, 0, 1, 0, 0, "sat_run");
    expect_int("eq_saturate", int'(eq_cnt), CNT_MAX);
    expect_int("sat_state_equal", int'(state), int'(ST_EQUAL));
    step(1, 0, 1, 0, 1, "clr_with_valid");
    expect_int("eq_cleared", int'(eq_cnt), 0);

    // Idle cycles between valid samples must not break or advance the run.
    do_reset();
    step(1, 1, 0, 0, 0, "tog1");
    step(0, 1, 0, 0, 0, "tog2");
    step(1, 1, 0, 0, 0, "tog3");
    step(0, 1, 0, 0, 0, "tog4");
    expect_int("tog_not_yet", int'(state), int'(ST_UNKNOWN));
    step(1, 1, 0, 0, 0, "tog5");
    expect_int("tog_update", int'(state), int'(ST_GREATER));
    step(0, 1, 0, 0, 0, "tog6");

    // Illegal flags.
    gt_before = int'(gt_cnt);
    step(1, 1, 0, 1, 0, "illegal_101");
`ifdef CMP_ONEHOT_CHECK_EN
    expect_int("illegal_err", int'(err_flag), 1);
    expect_int("illegal_gt_hold", int'(gt_cnt), gt_before);
    step(0, 0, 0, 0, 0, "illegal_idle");
    expect_int("err_sticky", int'(err_flag), 1);
`else
    expect_int("illegal_err0", int'(err_flag), 0);
    expect_int("illegal_as_gt", int'(gt_cnt), gt_before + 1);
`endif

    // Reset in the middle of a run discards the partial candidate.
    do_reset();
    step(1, 0, 0, 1, 0, "mid1");
    step(1, 0, 0, 1, 0, "mid2");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 1, 0, "post_rst1");
    expect_int("post_rst_no_update", int'(state), int'(ST_UNKNOWN));
    step(1, 0, 0, 1, 0, "post_rst2");
    step(1, 0, 0, 1, 0, "post_rst3");
    expect_int("post_rst_update", int'(state), int'(ST_LESS));

    // Random traffic with runs of one relation, occasional illegal flags and clears.
    rel = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 3) == 0) rel = $urandom_range(1, 3);
      g = (rel == 3); e = (rel == 2); l = (rel == 1);
      if ($urandom_range(0, 15) == 0) begin
        fl = 3'($urandom_range(0, 7));
        g = fl[2]; e = fl[1]; l = fl[0];
      end
      step($urandom_range(0, 3) != 0, g, e, l, $urandom_range(0, 49) == 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
